// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, frame constants and parity encodings.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  localparam int OVS        = 16;
  localparam int DATA_BITS  = 8;
  localparam int MID_SAMPLE = 7;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk pulse every round(CLK_FREQ/(BAUD*OVS)) clocks.
// Free-running, restartable to phase 0; no backpressure.
module uart_baud_tick #(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD     = 9600,
  parameter int OVS      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int TICK_DIV = (CLK_FREQ + (BAUD * OVS) / 2) / (BAUD * OVS);
  localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8-data/1-parity/1-stop UART receiver, 16x oversampled; rx_done strobes mid stop bit, no backpressure.
// Define UART_RX_MAJORITY_EN to take each bit as a 3-sample majority vote instead of one sample.
module uart_rx #(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD     = 9600,
  parameter int OVS      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       parity_sel,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);
  import uart_pkg::*;

  localparam int SW = $clog2(OVS);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] MID  = SW'(MID_SAMPLE);
  localparam logic [SW-1:0] LAST = SW'(OVS - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic          rx_meta_q, rx_s_q, rx_prev_q;
  logic [2:0]    state_q, state_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          psel_q, psel_d;
  logic          perr_q, perr_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_done_q, rx_done_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;
  logic          tick, restart, mid, last, bit_val;

  assign restart = (state_q == IDLE) && rx_prev_q && !rx_s_q;
  assign mid     = tick && (samp_q == MID);
  assign last    = tick && (samp_q == LAST);

  uart_baud_tick #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVS(OVS)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  // Vote over the three ticks ending at the decision tick, so latency matches the single-sample build.
  logic [1:0] hist_q;
  always_ff @(posedge clk) begin
    if (rst)       hist_q <= 2'b11;
    else if (tick) hist_q <= {hist_q[0], rx_s_q};
  end
  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
  assign bit_val = rx_s_q;
`endif

  always_comb begin
    state_d      = state_q;
    samp_d       = samp_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    psel_d       = psel_q;
    perr_d       = perr_q;
    rx_data_d    = rx_data_q;
    rx_done_d    = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    busy_d       = busy_q;
    if (state_q != IDLE && tick) samp_d = samp_q + 1'b1;
    case (state_q)
      IDLE: if (restart) begin
        state_d = START;
        samp_d  = '0;
        psel_d  = parity_sel;
        perr_d  = 1'b0;
        busy_d  = 1'b1;
      end
      START: begin
        if (mid && bit_val) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (last) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (mid) shift_d[idx_q] = bit_val;
        if (last) begin
          if (idx_q == IDX_LAST) state_d = PARITY;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      PARITY: begin
        if (mid)  perr_d  = bit_val ^ (^shift_q) ^ psel_q;
        if (last) state_d = STOP;
      end
      STOP: if (mid) begin
        rx_data_d    = shift_q;
        parity_err_d = perr_q;
        frame_err_d  = ~bit_val;
        rx_done_d    = 1'b1;
        if (bit_val) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: if (rx_s_q) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= IDLE;
      samp_q       <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      psel_q       <= 1'b0;
      perr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      rx_prev_q    <= rx_s_q;
      state_q      <= state_d;
      samp_q       <= samp_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      psel_q       <= psel_d;
      perr_q       <= perr_d;
      rx_data_q    <= rx_data_d;
      rx_done_q    <= rx_done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_done    = rx_done_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx, run with a reduced clock so one oversample tick is 4 clocks (64 clocks/bit).
module tb_uart_rx;

  localparam int CLK_FREQ = 614400;
  localparam int BAUD     = 9600;
  localparam int OVS      = 16;
  localparam int TDIV     = 4;
  localparam int BIT      = OVS * TDIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       parity_sel = 1'b0;
  logic [7:0] rx_data;
  logic       rx_done, parity_err, frame_err, rx_busy;

  always #20 clk = ~clk;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVS(OVS)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .parity_sel (parity_sel),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         done_cyc[$];
  logic [7:0] done_dat[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      done_cyc.push_back(cyc);
      done_dat.push_back(rx_data);
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       psel;
    logic       par;
    logic       stop;
    logic       flip;
    int         xlow;
    logic [7:0] ed;
    logic       eperr;
    logic       eferr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int xlow, input logic flip);
    send_bit(1'b0);
    if (flip) parity_sel = ~parity_sel;
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    for (int i = 0; i < xlow; i++) send_bit(1'b0);
  endtask

  initial begin
    int         n0;
    logic [7:0] d0;

    vecs[0] = '{8'hCD, 1'b0, 1'b1, 1'b1, 1'b0, 0, 8'hCD, 1'b0, 1'b0};
    vecs[1] = '{8'hCD, 1'b1, 1'b1, 1'b1, 1'b0, 0, 8'hCD, 1'b1, 1'b0};
    vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 2, 8'h55, 1'b0, 1'b1};
    vecs[3] = '{8'hA3, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'hA3, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h80, 1'b1, 1'b0};
    vecs[5] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 0, 8'h3C, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset rx_data", rx_data, 0);
    chk("reset rx_done", rx_done, 0);
    chk("reset parity_err", parity_err, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset rx_busy", rx_busy, 0);
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      parity_sel = vecs[i].psel;
      n0 = done_cyc.size();
      send_frame(vecs[i].d, vecs[i].par, vecs[i].stop, vecs[i].xlow, vecs[i].flip);
      if (vecs[i].xlow > 0) chk($sformatf("v%0d busy in break", i), rx_busy, 1);
      send_bit(1'b1);
      send_bit(1'b1);
      chk($sformatf("v%0d pulses", i), done_cyc.size() - n0, 1);
      chk($sformatf("v%0d rx_data", i), rx_data, vecs[i].ed);
      chk($sformatf("v%0d parity_err", i), parity_err, vecs[i].eperr);
      chk($sformatf("v%0d frame_err", i), frame_err, vecs[i].eferr);
      chk($sformatf("v%0d rx_busy", i), rx_busy, 0);
    end

    // Short low pulse while idle must be rejected at the start-bit midpoint.
    n0 = done_cyc.size();
    d0 = rx_data;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    chk("glitch busy rises", rx_busy, 1);
    repeat (BIT) @(negedge clk);
    chk("glitch busy falls", rx_busy, 0);
    chk("glitch no pulse", done_cyc.size() - n0, 0);
    chk("glitch data held", rx_data, d0);

    // Back-to-back frames with no idle gap.
    parity_sel = 1'b0;
    n0 = done_cyc.size();
    send_frame(8'h01, 1'b1, 1'b1, 0, 1'b0);
    send_frame(8'hFE, 1'b1, 1'b1, 0, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("b2b pulses", done_cyc.size() - n0, 2);
    if (done_cyc.size() >= n0 + 2) begin
      chk("b2b first data", done_dat[n0], 8'h01);
      chk("b2b second data", done_dat[n0+1], 8'hFE);
      chk("b2b spacing", done_cyc[n0+1] - done_cyc[n0], 16 * TDIV * 11);
    end
    chk("b2b parity_err", parity_err, 0);

    // Reset in the middle of data bit 4 of 0xF0 (odd parity): line stays high afterwards.
    parity_sel = 1'b1;
    n0 = done_cyc.size();
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    rx = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    chk("midframe busy", rx_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst rx_data", rx_data, 0);
    chk("rst rx_busy", rx_busy, 0);
    chk("rst rx_done", rx_done, 0);
    chk("rst parity_err", parity_err, 0);
    chk("rst frame_err", frame_err, 0);
    rst = 1'b0;
    repeat (BIT / 2 + 7 * BIT) @(negedge clk);
    chk("rst no pulse", done_cyc.size() - n0, 0);
    chk("rst busy idle", rx_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
